led_scroll_controller: RTL and testbench
========================================

# led_scroll_controller

Sequencer that feeds the 16-bit `ch` input of the four-digit LED driver. It stores a 16-character message of 4-bit codes and presents a four-character window of it on `ch`. The window scrolls automatically at a programmable rate, or one step at a time on command. It sits between the board's control logic (buttons or host writes) and the display driver, sharing the driver's `clk`.

## Interface
- `SHIFT_PERIOD`, default 50_000_000: `clk` cycles between automatic advances; minimum 2.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse; begin automatic scrolling.
- `stop`  in  1  one-cycle pulse; halt automatic scrolling.
- `step`  in  1  one-cycle pulse; advance one position while halted.
- `dir`  in  1  scroll direction: 0 = forward (ptr+1), 1 = backward (ptr-1); sampled at each advance.
- `wr_en`  in  1  message write strobe.
- `wr_addr`  in  4  message slot to write.
- `wr_data`  in  4  character code to write.
- `ch`  out  16  window to driver: `{msg[ptr], msg[ptr+1], msg[ptr+2], msg[ptr+3]}`, indices mod 16; `[15:12]` drives AN3.
- `ptr`  out  4  current window start index.
- `running`  out  1  high in state RUN.
- `wrap`  out  1  one-cycle pulse on the cycle after `ptr` wraps (15→0 forward, 0→15 backward).

## Operation
- Message store: 16 × 4-bit registers. Reset loads every slot with `CHAR_BLANK` (4'hF).
- Writes take effect at the sampling edge regardless of state. A write to a slot inside the current window appears on `ch` per the Timing section.
- FSM has two states, IDLE and RUN.
  - Reset state is IDLE.
  - IDLE→RUN on `start`. RUN→IDLE on `stop`.
  - Command priority: `reset` > `stop` > `start` > `step`.
  - If `stop` and `start` are asserted in the same cycle, the FSM stays in or goes to IDLE.
- Prescaler: counter 0..SHIFT_PERIOD-1, active only in RUN.
  - Cleared to 0 on the IDLE→RUN transition and whenever the FSM is in IDLE.
  - At terminal count it returns to 0 and `ptr` advances by one in direction `dir`.
- `step`: in IDLE, advances `ptr` by one in direction `dir`. Ignored in RUN.
  - Ignored in the same cycle as `start` or `stop`.
- `ptr` arithmetic is 4-bit modulo 16; wrap-around is natural overflow.
- Window indices ptr+1..ptr+3 are also mod 16 (e.g. ptr=14 shows slots 14,15,0,1).
- `stop` in the same cycle as a prescaler terminal count: the advance still happens, and the state becomes IDLE.
- Reset mid-scroll: `ptr`=0, prescaler=0, state IDLE, and the message is cleared.

## Timing
- Reset values, all visible the cycle after `reset` is sampled: `ch`=16'hFFFF, `ptr`=0, `running`=0, `wrap`=0.
- `ptr` and `running` are registered and update at the edge that samples the causing event.
- `ch` is registered and computed from the updated `ptr` and message. It therefore lags a `ptr` or message change by exactly one cycle.
- A write at edge k to a visible slot appears on `ch` at edge k+1.
- `wrap` is registered and asserts in the same cycle that `ch` first shows the wrapped window. It lasts exactly one cycle.
- Automatic advance cadence: first advance SHIFT_PERIOD cycles after the edge that sampled `start`. After that, one advance every SHIFT_PERIOD cycles with no jitter.
- No handshake back-pressure. Every command pulse is acted on or dropped in its own cycle.

## Structure
- Shared package `led_pkg`:
  - `CHAR_BLANK` = 4'hF.
  - `state_t` enum {IDLE, RUN}.
  - `char_t` typedef (logic [3:0]).
  - Shared by the display decoder for the blank glyph.
- One sub-module, `scroll_prescaler`: parameterised terminal counter with `clear`/`en` inputs and a one-cycle `tick` output.
- The FSM, message store and window mux stay in the top module.

## Test plan
- Reset check: assert `reset` for 2 cycles → `ch`=16'hFFFF, `ptr`=0, `running`=0, `wrap`=0 on the next cycle.
- Write and window: write slots 0..15 with values 0..F, no start → `ch`=16'h0123 one cycle after the last write.
- Step with wrap (`ptr`=0, `ch`=16'h0123): `dir`=1, pulse `step` once → `ptr`=15, `ch`=16'hF012, `wrap` pulses once.
- Auto scroll (SHIFT_PERIOD=4, message 0..F, `dir`=0): pulse `start` → `ptr` goes 1,2,3… every 4 cycles, first change 4 cycles after `start`; at 15→0, `ch`=16'h0123 with `wrap`=1 for one cycle.
- Collisions:
  - `start`+`stop` together → `running` stays 0.
  - `step` during RUN → no extra advance.
  - `stop` on a terminal count → advance occurs, `running`=0.
- Reset mid-RUN at `ptr`=9 → next cycle `ptr`=0, `running`=0, `ch`=16'hFFFF; no further advances.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED display path: character type, blank glyph
// and the scroll controller state encoding.
package led_pkg;

  typedef logic [3:0] char_t;

  localparam char_t CHAR_BLANK = 4'hF;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // One scroll position in the requested direction; 4-bit wrap is intended.
  function automatic logic [3:0] next_ptr(input logic [3:0] cur, input logic backward);
    return backward ? cur - 4'd1 : cur + 4'd1;
  endfunction

endpackage

// File: rtl/led_scroll_controller_prescaler.sv
// Free-running terminal counter for the scroll cadence; tick is high on the
// cycle whose edge wraps the counter back to zero.
module scroll_prescaler #(
  parameter int unsigned PERIOD = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int unsigned W = (PERIOD > 2) ? $clog2(PERIOD) : 1;
  localparam logic [W-1:0] TERMINAL = W'(PERIOD - 1);

  logic [W-1:0] count;

  assign tick = en && !clear && (count == TERMINAL);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      if (count == TERMINAL) count <= '0;
      else                   count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/led_scroll_controller.sv
// Message store plus scrolling four-character window feeding the LED driver.
// Automatic scrolling runs in RUN; single steps are accepted only in IDLE.
module led_scroll_controller
  import led_pkg::*;
#(
  parameter int unsigned SHIFT_PERIOD = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        dir,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [3:0]  wr_data,
  output logic [15:0] ch,
  output logic [3:0]  ptr,
  output logic        running,
  output logic        wrap
);

  state_t state, state_nx;
  char_t  msg [16];
  logic   tick;
  logic   advance;
  logic   wrapped;

  scroll_prescaler #(
    .PERIOD(SHIFT_PERIOD)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (state == IDLE),
    .en    (state == RUN),
    .tick  (tick)
  );

  always_comb begin
    state_nx = state;
    advance  = 1'b0;
    case (state)
      IDLE: begin
        if (stop)       state_nx = IDLE;
        else if (start) state_nx = RUN;
        else if (step)  advance  = 1'b1;
      end
      RUN: begin
        // A terminal count still advances even when stop lands on it.
        advance = tick;
        if (stop) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr     <= 4'd0;
      wrapped <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      wrapped <= advance && (dir ? (ptr == 4'd0) : (ptr == 4'd15));
      wrap    <= wrapped;
      if (advance) ptr <= next_ptr(ptr, dir);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) msg[i] <= CHAR_BLANK;
    end else if (wr_en) begin
      msg[wr_addr] <= wr_data;
    end
  end

  // Window is built from the already-registered ptr/message, hence one cycle of lag.
  always_ff @(posedge clk) begin
    if (reset) ch <= {4{CHAR_BLANK}};
    else       ch <= {msg[ptr], msg[ptr + 4'd1], msg[ptr + 4'd2], msg[ptr + 4'd3]};
  end

  assign running = (state == RUN);

endmodule

// File: tb/tb_led_scroll_controller.sv
// Scoreboard bench for led_scroll_controller: expectations are queued with the
// edge at which they must hold and compared by a negedge monitor.
module tb_led_scroll_controller;

  localparam int unsigned SP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0, stop = 1'b0, step = 1'b0, dir = 1'b0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = 4'd0, wr_data = 4'd0;
  logic [15:0] ch;
  logic [3:0]  ptr;
  logic        running, wrap;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [3:0] m_msg [16];

  typedef struct {
    int          due;
    int          kind;   // 0 ptr, 1 ch, 2 running, 3 wrap
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];

  led_scroll_controller #(.SHIFT_PERIOD(SP)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .step    (step),
    .dir     (dir),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .ch      (ch),
    .ptr     (ptr),
    .running (running),
    .wrap    (wrap)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at edge %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  task automatic expect_at(input string tag, input int kind, input int due, input logic [15:0] val);
    exp_t e;
    e.due = due; e.kind = kind; e.tag = tag; e.val = val;
    sb.push_back(e);
  endtask

  function automatic logic [15:0] win(input logic [3:0] p);
    logic [3:0] a;
    a = p;
    return {m_msg[a], m_msg[a + 4'd1], m_msg[a + 4'd2], m_msg[a + 4'd3]};
  endfunction

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].kind)
          0:       check(sb[i].tag, {12'd0, ptr}, sb[i].val);
          1:       check(sb[i].tag, ch, sb[i].val);
          2:       check(sb[i].tag, {15'd0, running}, sb[i].val);
          default: check(sb[i].tag, {15'd0, wrap}, sb[i].val);
        endcase
        sb.delete(i);
      end
    end
  end

  // Applies one cycle of inputs; e returns the edge that samples them.
  task automatic drive(input logic r, input logic st, input logic sp, input logic sk,
                       input logic d, input logic we, input logic [3:0] wa,
                       input logic [3:0] wd, output int e);
    @(negedge clk);
    reset = r; start = st; stop = sp; step = sk; dir = d;
    wr_en = we; wr_addr = wa; wr_data = wd;
    e = cyc + 1;
  endtask

  task automatic idle(input int n);
    int e;
    repeat (n) drive(1'b0, 1'b0, 1'b0, 1'b0, dir, 1'b0, 4'd0, 4'd0, e);
  endtask

  initial begin
    int e, s;

    for (int i = 0; i < 16; i++) m_msg[i] = 4'hF;

    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("rst_ch", 1, e, 16'hFFFF);
    expect_at("rst_ptr", 0, e, 16'd0);
    expect_at("rst_running", 2, e, 16'd0);
    expect_at("rst_wrap", 3, e, 16'd0);

    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'(i), 4'(i), e);
      m_msg[i] = 4'(i);
      if (i == 0) expect_at("wr_first_visible", 1, e + 1, win(4'd0));
    end
    expect_at("wr_window", 1, e + 1, 16'h0123);
    expect_at("wr_ptr", 0, e + 1, 16'd0);
    idle(2);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, e);
    expect_at("stepb_ptr", 0, e, 16'hF);
    expect_at("stepb_wrap_pre", 3, e, 16'd0);
    expect_at("stepb_ch", 1, e + 1, 16'hF012);
    expect_at("stepb_wrap", 3, e + 1, 16'd1);
    expect_at("stepb_wrap_end", 3, e + 2, 16'd0);
    idle(3);

    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("stepf_ptr", 0, e, 16'd0);
    expect_at("stepf_ch", 1, e + 1, 16'h0123);
    expect_at("stepf_wrap", 3, e + 1, 16'd1);
    idle(3);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, s);
    expect_at("run_start", 2, s, 16'd1);
    for (int k = 1; k <= 17; k++) begin
      expect_at("auto_ptr_hold", 0, s + 4 * k - 1, 16'((k - 1) % 16));
      expect_at("auto_ptr", 0, s + 4 * k, 16'(k % 16));
      expect_at("auto_ch", 1, s + 4 * k + 1, win(4'(k % 16)));
    end
    expect_at("auto_wrap_pre", 3, s + 64, 16'd0);
    expect_at("auto_wrap", 3, s + 65, 16'd1);
    expect_at("auto_wrap_end", 3, s + 66, 16'd0);
    expect_at("auto_running", 2, s + 67, 16'd1);
    expect_at("stop_tc_running", 2, s + 68, 16'd0);
    expect_at("stop_tc_halted", 0, s + 76, 16'd1);
    for (int c = 1; c <= 68; c++) begin
      drive(1'b0, 1'b0, (c == 68), (c == 2 || c == 6), 1'b0, 1'b0, 4'd0, 4'd0, e);
    end
    idle(9);

    drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("startstop_running", 2, e, 16'd0);
    expect_at("startstop_ptr", 0, e + 3, 16'd1);
    idle(3);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("stepstop_ptr", 0, e, 16'd1);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("stepstart_ptr", 0, e, 16'd1);
    expect_at("stepstart_running", 2, e, 16'd1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e);
    expect_at("stop_running", 2, e, 16'd0);
    expect_at("stop_ptr", 0, e + 4, 16'd1);
    idle(6);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, s);
    expect_at("mid_ptr9", 0, s + 32, 16'd9);
    expect_at("mid_rst_ptr", 0, s + 33, 16'd0);
    expect_at("mid_rst_running", 2, s + 33, 16'd0);
    expect_at("mid_rst_ch", 1, s + 33, 16'hFFFF);
    expect_at("mid_rst_wrap", 3, s + 33, 16'd0);
    expect_at("post_rst_ptr", 0, s + 43, 16'd0);
    expect_at("post_rst_ch", 1, s + 43, 16'hFFFF);
    expect_at("post_rst_running", 2, s + 43, 16'd0);
    for (int c = 1; c <= 33; c++) begin
      drive((c == 33), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, e);
    end
    for (int i = 0; i < 16; i++) m_msg[i] = 4'hF;
    idle(12);

    check("sb_drain", 16'(sb.size()), 16'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
